// File: rtl/pl_io_pkg.sv
// Shared word map, data width and in_port field layout for the MEM-stage I/O bridge.
package pl_io_pkg;

    localparam int DATA_W = 32;
    localparam int WIDX_W = 6;

    localparam logic [WIDX_W-1:0] IN_BASE  = 6'h00;
    localparam logic [WIDX_W-1:0] OUT_BASE = 6'h10;
    localparam logic [WIDX_W-1:0] PEND     = 6'h20;
    localparam logic [WIDX_W-1:0] TOGG     = 6'h21;
    localparam logic [WIDX_W-1:0] IRQEN    = 6'h22;

    typedef enum logic [2:0] {
        W_NONE,
        W_IN,
        W_OUT,
        W_PEND,
        W_TOGG,
        W_IRQEN
    } word_kind_e;

    // in_port word: switches in the low SW_W bits, toggle directly above them.
    function automatic int toggle_pos(input int sw_w);
        return sw_w;
    endfunction

    function automatic word_kind_e decode_word(input logic [WIDX_W-1:0] widx,
                                               input int n_in,
                                               input int n_out);
        word_kind_e kind;
        int w;
        w    = int'(widx);
        kind = W_NONE;
        if (w >= int'(IN_BASE) && w < int'(IN_BASE) + n_in) begin
            kind = W_IN;
        end else if (w >= int'(OUT_BASE) && w < int'(OUT_BASE) + n_out) begin
            kind = W_OUT;
        end else if (widx == PEND) begin
            kind = W_PEND;
        end else if (widx == TOGG) begin
            kind = W_TOGG;
        end else if (widx == IRQEN) begin
            kind = W_IRQEN;
        end
        return kind;
    endfunction

endpackage

// File: rtl/pl_io_debounce.sv
// One button channel: two-flop synchroniser, stable-count debouncer and a
// single-cycle press strobe on an accepted 1->0 transition.
module pl_io_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        meta_d = btn_raw;
        sync_d = meta_q;
        deb_d  = deb_q;
        cnt_d  = '0;
        if (sync_q != deb_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                deb_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Strobe is taken from the accepting edge so the event lands on the same
    // clock that updates deb, giving 2 + DEB_CYCLES cycles end to end.
    assign press = deb_q & ~deb_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            deb_q  <= 1'b1;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/pl_io_bridge.sv
// Memory-mapped I/O bridge for the MEM stage: debounced button channels with
// toggle/pending/irq state, synchronised switches and latched output ports.
module pl_io_bridge
    import pl_io_pkg::*;
#(
    parameter int N_IN       = 2,
    parameter int N_OUT      = 3,
    parameter int SW_W       = 4,
    parameter int DEB_CYCLES = 16
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    we,
    input  logic [7:0]              addr,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata,
    input  logic [N_IN-1:0]         btn,
    input  logic [N_IN*SW_W-1:0]    sw,
    output logic [N_IN-1:0]         led,
    output logic [N_OUT*DATA_W-1:0] out_port,
    output logic                    irq
);

    localparam int TOG_BIT = toggle_pos(SW_W);

    logic [WIDX_W-1:0]    widx;
    word_kind_e           kind;
    logic [N_IN-1:0]      press;
    logic                 unused_addr_lsb;

    logic [N_IN*SW_W-1:0] sw_meta_q, sw_meta_d;
    logic [N_IN*SW_W-1:0] sw_sync_q, sw_sync_d;
    logic [N_IN-1:0]      toggle_q, toggle_d;
    logic [N_IN-1:0]      pending_q, pending_d;
    logic [N_IN-1:0]      irq_en_q, irq_en_d;
    logic [DATA_W-1:0]    out_q [N_OUT];
    logic [DATA_W-1:0]    out_d [N_OUT];

    assign widx            = addr[7:2];
    assign unused_addr_lsb = ^addr[1:0];
    assign kind            = decode_word(widx, N_IN, N_OUT);

    function automatic logic [DATA_W-1:0] in_word(input logic [SW_W-1:0] s,
                                                  input logic            t);
        logic [DATA_W:0] w;
        w             = '0;
        w[SW_W-1:0]   = s;
        w[TOG_BIT]    = t;
        return w[DATA_W-1:0];
    endfunction

    for (genvar k = 0; k < N_IN; k++) begin : g_btn
        pl_io_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clock  (clock),
            .resetn (resetn),
            .btn_raw(btn[k]),
            .press  (press[k])
        );
    end

    always_comb begin
        sw_meta_d = sw;
        sw_sync_d = sw_meta_q;
        toggle_d  = toggle_q;
        pending_d = pending_q;
        irq_en_d  = irq_en_q;
        for (int i = 0; i < N_OUT; i++) begin
            out_d[i] = out_q[i];
        end

        if (we) begin
            case (kind)
                W_OUT: begin
                    for (int i = 0; i < N_OUT; i++) begin
                        if (widx == OUT_BASE + WIDX_W'(i)) begin
                            out_d[i] = wdata;
                        end
                    end
                end
                W_PEND:  pending_d = pending_q & ~wdata[N_IN-1:0];
                W_TOGG:  toggle_d  = wdata[N_IN-1:0];
                W_IRQEN: irq_en_d  = wdata[N_IN-1:0];
                default: ;
            endcase
        end

        // Press is applied after the bus write: a same-cycle press flips the
        // written toggle value and overrides a write-1-to-clear of pending.
        toggle_d  = toggle_d ^ press;
        pending_d = pending_d | press;
    end

    always_comb begin
        rdata = '0;
        case (kind)
            W_IN: begin
                for (int i = 0; i < N_IN; i++) begin
                    if (widx == IN_BASE + WIDX_W'(i)) begin
                        rdata = in_word(sw_sync_q[i*SW_W +: SW_W], toggle_q[i]);
                    end
                end
            end
            W_OUT: begin
                for (int i = 0; i < N_OUT; i++) begin
                    if (widx == OUT_BASE + WIDX_W'(i)) begin
                        rdata = out_q[i];
                    end
                end
            end
            W_PEND:  rdata[N_IN-1:0] = pending_q;
            W_TOGG:  rdata[N_IN-1:0] = toggle_q;
            W_IRQEN: rdata[N_IN-1:0] = irq_en_q;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            toggle_q  <= '0;
            pending_q <= '0;
            irq_en_q  <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            toggle_q  <= toggle_d;
            pending_q <= pending_d;
            irq_en_q  <= irq_en_d;
            for (int i = 0; i < N_OUT; i++) begin
                out_q[i] <= out_d[i];
            end
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign out_port[k*DATA_W +: DATA_W] = out_q[k];
    end

    assign led = toggle_q;
    assign irq = |(pending_q & irq_en_q);

endmodule
